// File: rtl/move_entry_if.sv
// Move-entry handshake bundle: keystroke input, board state, and the move/pending outputs.
// The master side drives keys, board state and move_ack. The slave side is the sequencer.
interface move_entry_if;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic [8:0] occupied;
    logic       game_over;
    logic       move_ack;
    logic       move_valid;
    logic [3:0] move_pos;
    logic [1:0] move_tile;
    logic [3:0] pend_pos;
    logic [1:0] pend_tile;
    logic       err;
    logic       locked;

    modport master (
        output key_valid, key_ascii, occupied, game_over, move_ack,
        input  move_valid, move_pos, move_tile, pend_pos, pend_tile, err, locked
    );

    modport slave (
        input  key_valid, key_ascii, occupied, game_over, move_ack,
        output move_valid, move_pos, move_tile, pend_pos, pend_tile, err, locked
    );
endinterface

// File: rtl/move_entry.sv
// Keyboard move-entry sequencer: builds cell+tile from keys and offers it to game control.
// Latency 1 cycle per key; a finished move is held on move_valid until move_ack, and keys are dropped meanwhile.
module move_entry #(
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    move_entry_if.slave  bus
);

    localparam logic [27:0] TO_LOAD = 28'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HAVE_POS,
        HAVE_TILE,
        ISSUE,
        LOCKED
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  pend_pos_q, pend_pos_nx;
    logic [1:0]  pend_tile_q, pend_tile_nx;
    logic [3:0]  move_pos_q, move_pos_nx;
    logic [1:0]  move_tile_q, move_tile_nx;
    logic        err_q, err_nx;
    logic [27:0] cnt_q, cnt_nx;

    logic       is_digit, is_red, is_blue, is_tile, is_enter, is_bksp, is_esc;
    logic       known_key;
    logic [3:0] digit;
    logic [1:0] tile_code;
    logic [3:0] digit_idx, pend_idx;
    logic       digit_occ, pend_occ;
    logic       timed, key_ok, expire;

    // ASCII '1'..'9' carry the cell number in their low nibble.
    assign is_digit  = (bus.key_ascii >= 8'h31) && (bus.key_ascii <= 8'h39);
    assign digit     = bus.key_ascii[3:0];
    assign is_red    = (bus.key_ascii == 8'h72) || (bus.key_ascii == 8'h52);
    assign is_blue   = (bus.key_ascii == 8'h62) || (bus.key_ascii == 8'h42);
    assign is_tile   = is_red || is_blue;
    assign tile_code = is_red ? 2'b10 : 2'b01;
    assign is_enter  = (bus.key_ascii == 8'h0D);
    assign is_bksp   = (bus.key_ascii == 8'h08);
    assign is_esc    = (bus.key_ascii == 8'h1B);
    assign known_key = is_digit || is_tile || is_enter || is_bksp || is_esc;

    assign digit_idx = digit - 4'd1;
    assign pend_idx  = pend_pos_q - 4'd1;
    assign digit_occ = bus.occupied[digit_idx];
    assign pend_occ  = bus.occupied[pend_idx];

    assign timed = (state == HAVE_POS) || (state == HAVE_TILE);

    always_comb begin
        state_nx     = state;
        pend_pos_nx  = pend_pos_q;
        pend_tile_nx = pend_tile_q;
        move_pos_nx  = move_pos_q;
        move_tile_nx = move_tile_q;
        err_nx       = 1'b0;
        key_ok       = 1'b0;
        expire       = 1'b0;
        cnt_nx       = TO_LOAD;

        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    if (is_digit) begin
                        if (digit_occ) begin
                            err_nx = 1'b1;
                        end else begin
                            pend_pos_nx = digit;
                            state_nx    = HAVE_POS;
                        end
                    end else if (is_tile || is_enter || is_bksp) begin
                        err_nx = 1'b1;
                    end
                end
            end
            HAVE_POS: begin
                if (bus.key_valid) begin
                    if (is_tile) begin
                        pend_tile_nx = tile_code;
                        state_nx     = HAVE_TILE;
                    end else if (is_digit) begin
                        if (digit_occ) err_nx = 1'b1;
                        else           pend_pos_nx = digit;
                    end else if (is_enter) begin
                        err_nx = 1'b1;
                    end else if (is_bksp || is_esc) begin
                        pend_pos_nx = 4'd0;
                        state_nx    = IDLE;
                    end
                end
            end
            HAVE_TILE: begin
                if (bus.key_valid) begin
                    if (is_enter) begin
                        // Board may have changed since the digit was typed; recheck at commit.
                        if (!pend_occ) begin
                            move_pos_nx  = pend_pos_q;
                            move_tile_nx = pend_tile_q;
                            state_nx     = ISSUE;
                        end else begin
                            err_nx       = 1'b1;
                            pend_pos_nx  = 4'd0;
                            pend_tile_nx = 2'd0;
                            state_nx     = IDLE;
                        end
                    end else if (is_tile) begin
                        pend_tile_nx = tile_code;
                    end else if (is_bksp) begin
                        pend_tile_nx = 2'd0;
                        state_nx     = HAVE_POS;
                    end else if (is_esc) begin
                        pend_pos_nx  = 4'd0;
                        pend_tile_nx = 2'd0;
                        state_nx     = IDLE;
                    end else if (is_digit) begin
                        err_nx = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.move_ack) begin
                    pend_pos_nx  = 4'd0;
                    pend_tile_nx = 2'd0;
                    move_pos_nx  = 4'd0;
                    move_tile_nx = 2'd0;
                    state_nx     = IDLE;
                end
            end
            LOCKED: begin
                state_nx = LOCKED;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A processed key wins over a coincident expiry and restarts the idle window.
        key_ok = timed && bus.key_valid && known_key && !err_nx;
        if (timed) begin
            if (key_ok) begin
                cnt_nx = TO_LOAD;
            end else if (cnt_q != 28'd0) begin
                cnt_nx = cnt_q - 28'd1;
            end else begin
                expire = 1'b1;
            end
        end

        if (expire) begin
            pend_pos_nx  = 4'd0;
            pend_tile_nx = 2'd0;
            state_nx     = IDLE;
            cnt_nx       = TO_LOAD;
        end

        if (bus.game_over) begin
            state_nx     = LOCKED;
            pend_pos_nx  = 4'd0;
            pend_tile_nx = 2'd0;
            move_pos_nx  = 4'd0;
            move_tile_nx = 2'd0;
            err_nx       = 1'b0;
            cnt_nx       = TO_LOAD;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state       <= IDLE;
            pend_pos_q  <= 4'd0;
            pend_tile_q <= 2'd0;
            move_pos_q  <= 4'd0;
            move_tile_q <= 2'd0;
            err_q       <= 1'b0;
            cnt_q       <= TO_LOAD;
        end else begin
            state       <= state_nx;
            pend_pos_q  <= pend_pos_nx;
            pend_tile_q <= pend_tile_nx;
            move_pos_q  <= move_pos_nx;
            move_tile_q <= move_tile_nx;
            err_q       <= err_nx;
            cnt_q       <= cnt_nx;
        end
    end

    assign bus.move_valid = (state == ISSUE);
    assign bus.locked     = (state == LOCKED);
    assign bus.move_pos   = move_pos_q;
    assign bus.move_tile  = move_tile_q;
    assign bus.pend_pos   = pend_pos_q;
    assign bus.pend_tile  = pend_tile_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_move_entry.sv
// Directed vector bench for move_entry with a short timeout window.
module tb_move_entry;

    localparam logic [7:0] K_ENT = 8'h0D;
    localparam logic [7:0] K_BS  = 8'h08;
    localparam logic [7:0] K_ESC = 8'h1B;
    localparam logic [7:0] K_X   = 8'h78;
    localparam logic [8:0] OCC3  = 9'h004;

    typedef struct {
        logic       rn;
        logic       kv;
        logic [7:0] ka;
        logic [8:0] occ;
        logic       go;
        logic       ack;
        logic       mv;
        logic [3:0] mp;
        logic [1:0] mt;
        logic [3:0] pp;
        logic [1:0] pt;
        logic       er;
        logic       lk;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   applied = 0;
    int   miscompares = 0;

    move_entry_if bus ();

    move_entry #(.TIMEOUT_CYCLES(16)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rn, input logic kv, input logic [7:0] ka,
                                input logic [8:0] occ, input logic go, input logic ack,
                                input logic mv, input logic [3:0] mp, input logic [1:0] mt,
                                input logic [3:0] pp, input logic [1:0] pt,
                                input logic er, input logic lk);
        vec_t v;
        v.rn = rn; v.kv = kv; v.ka = ka; v.occ = occ; v.go = go; v.ack = ack;
        v.mv = mv; v.mp = mp; v.mt = mt; v.pp = pp; v.pt = pt; v.er = er; v.lk = lk;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name);
        logic [14:0] got, exp;
        resetn        = v.rn;
        bus.key_valid = v.kv;
        bus.key_ascii = v.ka;
        bus.occupied  = v.occ;
        bus.game_over = v.go;
        bus.move_ack  = v.ack;
        @(posedge clk);
        #1;
        got = {bus.move_valid, bus.move_pos, bus.move_tile, bus.pend_pos, bus.pend_tile, bus.err, bus.locked};
        exp = {v.mv, v.mp, v.mt, v.pp, v.pt, v.er, v.lk};
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got mv=%b pos=%0d tile=%b pend=%0d/%b err=%b lk=%b, expected mv=%b pos=%0d tile=%b pend=%0d/%b err=%b lk=%b",
                     name, bus.move_valid, bus.move_pos, bus.move_tile, bus.pend_pos, bus.pend_tile,
                     bus.err, bus.locked, v.mv, v.mp, v.mt, v.pp, v.pt, v.er, v.lk);
        end
    endtask

    vec_t tbl[$];

    initial begin
        resetn = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_ascii = 8'h00;
        bus.occupied  = 9'h000;
        bus.game_over = 1'b0;
        bus.move_ack  = 1'b0;

        //               rn kv ka     occ     go ack  mv mp mt    pp pt    er lk
        tbl.push_back(mk(0, 0, 8'h00, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h35, 9'h000, 0, 0,  0, 0, 2'd0, 5, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h72, 9'h000, 0, 0,  0, 0, 2'd0, 5, 2'd2, 0, 0));
        tbl.push_back(mk(1, 1, K_ENT, 9'h000, 0, 0,  1, 5, 2'd2, 5, 2'd2, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0,  1, 5, 2'd2, 5, 2'd2, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 9'h000, 0, 1,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h33, OCC3,   0, 0,  0, 0, 2'd0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, OCC3,   0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h34, OCC3,   0, 0,  0, 0, 2'd0, 4, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h42, OCC3,   0, 0,  0, 0, 2'd0, 4, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, K_BS,  OCC3,   0, 0,  0, 0, 2'd0, 4, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h62, OCC3,   0, 0,  0, 0, 2'd0, 4, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, K_ENT, OCC3,   0, 0,  1, 4, 2'd1, 4, 2'd1, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, OCC3,   0, 1,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h72, OCC3,   0, 0,  0, 0, 2'd0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 1, K_ENT, OCC3,   0, 0,  0, 0, 2'd0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 1, K_ESC, OCC3,   0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, K_X,   OCC3,   0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h36, OCC3,   0, 0,  0, 0, 2'd0, 6, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, K_X,   OCC3,   0, 0,  0, 0, 2'd0, 6, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, K_ENT, OCC3,   0, 0,  0, 0, 2'd0, 6, 2'd0, 1, 0));
        tbl.push_back(mk(1, 1, 8'h33, OCC3,   0, 0,  0, 0, 2'd0, 6, 2'd0, 1, 0));
        tbl.push_back(mk(1, 1, 8'h38, OCC3,   0, 0,  0, 0, 2'd0, 8, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h52, OCC3,   0, 0,  0, 0, 2'd0, 8, 2'd2, 0, 0));
        tbl.push_back(mk(1, 1, K_X,   OCC3,   0, 0,  0, 0, 2'd0, 8, 2'd2, 0, 0));
        tbl.push_back(mk(1, 1, 8'h32, OCC3,   0, 0,  0, 0, 2'd0, 8, 2'd2, 1, 0));
        tbl.push_back(mk(1, 1, 8'h62, OCC3,   0, 0,  0, 0, 2'd0, 8, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, K_ESC, OCC3,   0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h31, OCC3,   0, 0,  0, 0, 2'd0, 1, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h72, OCC3,   0, 0,  0, 0, 2'd0, 1, 2'd2, 0, 0));
        tbl.push_back(mk(1, 1, K_ENT, 9'h001, 0, 0,  0, 0, 2'd0, 0, 2'd0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h32, 9'h000, 0, 0,  0, 0, 2'd0, 2, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, K_BS,  9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h39, 9'h000, 0, 0,  0, 0, 2'd0, 9, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h72, 9'h000, 0, 0,  0, 0, 2'd0, 9, 2'd2, 0, 0));
        tbl.push_back(mk(1, 1, K_ENT, 9'h000, 0, 0,  1, 9, 2'd2, 9, 2'd2, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 9'h000, 1, 0,  0, 0, 2'd0, 0, 2'd0, 0, 1));
        tbl.push_back(mk(1, 1, 8'h35, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 1));
        tbl.push_back(mk(1, 1, 8'h72, 9'h000, 0, 1,  0, 0, 2'd0, 0, 2'd0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h35, 9'h000, 0, 0,  0, 0, 2'd0, 5, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, K_ESC, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h33, 9'h000, 1, 0,  0, 0, 2'd0, 0, 2'd0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h35, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h31, 9'h000, 0, 0,  0, 0, 2'd0, 1, 2'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h62, 9'h000, 0, 0,  0, 0, 2'd0, 1, 2'd1, 0, 0));
        tbl.push_back(mk(1, 1, K_ENT, 9'h000, 0, 0,  1, 1, 2'd1, 1, 2'd1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 9'h000, 0, 0,  0, 0, 2'd0, 0, 2'd0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Move held through 20 cycles of typing with no ack.
        step(mk(1, 1, 8'h37, 9'h000, 0, 0, 0, 0, 2'd0, 7, 2'd0, 0, 0), "hold_7");
        step(mk(1, 1, 8'h52, 9'h000, 0, 0, 0, 0, 2'd0, 7, 2'd2, 0, 0), "hold_R");
        step(mk(1, 1, K_ENT, 9'h000, 0, 0, 1, 7, 2'd2, 7, 2'd2, 0, 0), "hold_enter");
        for (int i = 0; i < 20; i++) begin
            logic [7:0] k;
            k = (i % 3 == 0) ? 8'h32 : ((i % 3 == 1) ? 8'h62 : K_X);
            step(mk(1, 1, k, 9'h000, 0, 0, 1, 7, 2'd2, 7, 2'd2, 0, 0), $sformatf("hold_wait%0d", i));
        end
        step(mk(1, 0, 8'h00, 9'h000, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0), "hold_ack");
        step(mk(1, 1, 8'h35, 9'h000, 0, 0, 0, 0, 2'd0, 5, 2'd0, 0, 0), "hold_idle_after");
        step(mk(1, 1, K_ESC, 9'h000, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0), "hold_esc");

        // Partial entry discarded after 16 idle cycles.
        step(mk(1, 1, 8'h31, 9'h000, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0), "to_key1");
        for (int k = 1; k <= 15; k++) begin
            step(mk(1, 0, 8'h00, 9'h000, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0), $sformatf("to_wait%0d", k));
        end
        step(mk(1, 0, 8'h00, 9'h000, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0), "to_expire");

        // Key on the expiry cycle is processed and restarts the window.
        step(mk(1, 1, 8'h31, 9'h000, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0), "tok_key1");
        for (int k = 1; k <= 15; k++) begin
            step(mk(1, 0, 8'h00, 9'h000, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0), $sformatf("tok_wait%0d", k));
        end
        step(mk(1, 1, 8'h72, 9'h000, 0, 0, 0, 0, 2'd0, 1, 2'd2, 0, 0), "tok_key_on_expiry");
        for (int k = 1; k <= 15; k++) begin
            step(mk(1, 0, 8'h00, 9'h000, 0, 0, 0, 0, 2'd0, 1, 2'd2, 0, 0), $sformatf("tok_rewait%0d", k));
        end
        step(mk(1, 0, 8'h00, 9'h000, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0), "tok_expire");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
